// File: rtl/sys_array_pkg.sv
// Shared types and helpers for the systolic-array result scanner.
//   state_e    : scan FSM encoding (IDLE, SCAN, DONE)
//   clog2_min1 : $clog2 clamped to at least 1, for index widths
package sys_array_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sys_array_result_scanner_rise_detect.sv
// Registered-history rising-edge detector.
//   clk, reset_n : clock, synchronous active-low reset (history cleared)
//   d            : level input
//   rise         : d & ~d_q, combinational, high for the cycle d first reads 1
// Because reset clears the history, a level already high when reset is
// released is reported as a rise on the first edge out of reset.
module rise_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise
);

  logic d_q;
  logic d_d;

  always_comb begin
    d_d = d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) d_q <= 1'b0;
    else          d_q <= d_d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/sys_array_result_scanner.sv
// Snapshots the fetcher's ARRAY_W x ARRAY_W result matrix on a rising edge
// of ready, then walks it row-major, one element per step_tick.
//   clk, reset_n : clock, synchronous active-low reset
//   ready        : fetcher result-valid level; a rise captures result_in
//   result_in    : fetcher result matrix, read only on the capture edge
//   step_tick    : advance strobe
//   hold         : freeze scan position (ticks during hold are dropped)
//   loop_mode    : 1 wrap after the last element, 0 stop in DONE
//   value_out    : current snapshot element (0 when not scanning)
//   row_idx      : current row
//   col_idx      : current column
//   valid_out    : high while scanning
//   pass_done    : one-cycle pulse after stepping off the last element
module sys_array_result_scanner
  import sys_array_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W    = 5,
  localparam int IDX_W     = clog2_min1(ARRAY_W)
) (
  input  logic                                                   clk,
  input  logic                                                   reset_n,
  input  logic                                                   ready,
  input  logic [0:ARRAY_W-1][0:ARRAY_W-1][2*DATA_WIDTH-1:0]      result_in,
  input  logic                                                   step_tick,
  input  logic                                                   hold,
  input  logic                                                   loop_mode,
  output logic [2*DATA_WIDTH-1:0]                                value_out,
  output logic [IDX_W-1:0]                                       row_idx,
  output logic [IDX_W-1:0]                                       col_idx,
  output logic                                                   valid_out,
  output logic                                                   pass_done
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(ARRAY_W - 1);

  logic rise;

  state_e                                              state_q, state_d;
  logic [IDX_W-1:0]                                    row_q, row_d;
  logic [IDX_W-1:0]                                    col_q, col_d;
  logic [0:ARRAY_W-1][0:ARRAY_W-1][2*DATA_WIDTH-1:0]   buf_q, buf_d;
  logic                                                pass_done_q, pass_done_d;

  rise_detect u_ready_rise (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (ready),
    .rise   (rise)
  );

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    buf_d       = buf_q;
    pass_done_d = 1'b0;

    // Capture has priority over everything else, from any state.
    if (rise) begin
      buf_d   = result_in;
      row_d   = '0;
      col_d   = '0;
      state_d = SCAN;
    end else if (state_q == SCAN && step_tick && !hold) begin
      if (col_q != LAST) begin
        col_d = col_q + IDX_W'(1);
      end else if (row_q != LAST) begin
        col_d = '0;
        row_d = row_q + IDX_W'(1);
      end else begin
        pass_done_d = 1'b1;
        row_d       = '0;
        col_d       = '0;
        state_d     = loop_mode ? SCAN : DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      buf_q       <= '0;
      pass_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      buf_q       <= buf_d;
      pass_done_q <= pass_done_d;
    end
  end

  assign valid_out = (state_q == SCAN);
  assign value_out = valid_out ? buf_q[row_q][col_q] : '0;
  assign row_idx   = row_q;
  assign col_idx   = col_q;
  assign pass_done = pass_done_q;

endmodule

// File: doc/sys_array_result_scanner.md
Name: sys_array_result_scanner

Overview:
- Downstream consumer of the systolic fetcher's result matrix.
- Snapshots the ARRAY_W x ARRAY_W result matrix when the fetcher's ready rises.
- Walks the snapshot row-major, one element per step_tick pulse, presenting value and coordinates for the seven-segment path.
- Replaces the free-running shift-register readout with an explicit, pausable, restartable scan.

Parameters:
- DATA_WIDTH, 8, operand width; each result element is 2*DATA_WIDTH bits.
- ARRAY_W, 5, matrix dimension; the result is ARRAY_W x ARRAY_W.
- IDX_W, $clog2(ARRAY_W) (min 1), derived localparam, width of row/col indices.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; synchronous, active-low.
- ready  in  1  fetcher result-valid level; a rising edge means a new matrix.
- result_in  in  [0:ARRAY_W-1][0:ARRAY_W-1][2*DATA_WIDTH-1:0]  fetcher result matrix, meaningful while ready=1.
- step_tick  in  1  one-cycle advance strobe from the clock-divider count.
- hold  in  1  freeze the scan position while high.
- loop_mode  in  1  1: wrap to (0,0) after the last element; 0: stop after one pass.
- value_out  out  2*DATA_WIDTH  current element of the snapshot.
- row_idx  out  IDX_W  current row.
- col_idx  out  IDX_W  current column.
- valid_out  out  1  value_out/row_idx/col_idx are meaningful.
- pass_done  out  1  one-cycle pulse on the step off element (W-1,W-1).

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE, ready_q=0, row=col=0, snapshot buffer cleared.
  - value_out=0, row_idx=0, col_idx=0, valid_out=0, pass_done=0.
  - Applies mid-scan too; nothing in progress survives.
- Edge detection: ready_q is ready registered each cycle; rise = ready & ~ready_q.
- States:
  - IDLE: valid_out=0, value_out=0.
  - SCAN: valid_out=1.
  - DONE: one-pass complete; valid_out=0, buffer retained.
- Capture: on any edge where rise=1, regardless of state:
  - Load the whole result_in into the buffer in one cycle.
  - row=col=0, state=SCAN.
  - A capture always wins over step_tick, hold and pass completion in the same cycle.
- Latency: value_out=buf[0][0] and valid_out=1 in the cycle right after the capture edge. value_out is a combinational mux of registered buf and registered row/col.
- Advance rule in SCAN, on an edge with step_tick=1, hold=0, rise=0:
  - col<W-1: col+1.
  - col=W-1 and row<W-1: col=0, row+1.
  - col=W-1 and row=W-1: pass_done=1 for exactly one cycle (registered, the cycle after this edge).
    - loop_mode=1: row=col=0, stay in SCAN.
    - loop_mode=0: go to DONE; valid_out=0 from the next cycle.
- hold=1: row/col frozen and step_tick ignored. A tick coincident with hold is lost, not queued. Capture still works while hold=1.
- ready falling while in SCAN: no effect; the scan continues on the snapshot. result_in is never read outside the capture cycle.
- ready held high: no recapture; only a fresh rise recaptures.
- DONE → SCAN only via a new rise. DONE never returns to IDLE except by reset.
- loop_mode is sampled only at the last-element step.
- Arithmetic: indices count within 0..W-1 only. Values are passed through unmodified, no sign handling.

Decomposition:
- sys_array_pkg:
  - state typedef enum logic [1:0] {IDLE, SCAN, DONE}.
  - function clog2_min1 for IDX_W.
- Sub-module rise_detect (clk, reset_n, d, rise): registered-history edge detector, also reusable for start_comp/load_params button conditioning.
- Buffer, index counters and FSM stay in the top module.

Test Plan (bench with DATA_WIDTH=8, ARRAY_W=3; result_in[r][c]=16'h0100*r+c):
- Reset, then ready 0→1 → next cycle valid_out=1, row/col=0/0, value_out=16'h0000; without ticks it stays on (0,0).
- Eight step_tick pulses with loop_mode=0 → sequence (0,1)=0001 … (2,2)=0202. Ninth tick → pass_done pulse of 1 cycle, state DONE, valid_out=0.
- loop_mode=1, nine ticks → pass_done pulses once and the position returns to (0,0)=0000 with valid_out held 1.
- At (1,1) assert hold for 4 ticks → position stays (1,1)=0101. Deassert hold, one tick → (1,2)=0102.
- At (1,2) drop ready and change result_in to 16'hFFFF → value_out keeps snapshot values. Raise ready with a coincident step_tick → recapture, position (0,0), value 16'hFFFF.
- Assert reset_n=0 for one edge at (2,0) → all outputs 0, valid_out=0. Holding ready high after reset with no new rise → after reset ready_q=0, so ready still high at the next edge counts as a rise and captures.
